// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus for the program loader.
// Handshake: a byte moves on a rising clock edge where byte_valid and
// byte_ready are both high. The source holds byte_data stable while
// byte_valid is high, and it may raise or drop byte_valid on any cycle.
// The loader raises byte_ready only while it is collecting bytes.
// imem_we is a write strobe. Memory writes imem_wdata at imem_addr on each
// edge where imem_we is high, and it has no backpressure.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // The loader drives memory and consumes bytes.
    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    // The environment supplies bytes and receives memory writes.
    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader. It packs incoming bytes into big-endian 32-bit words and
// writes them to instruction memory starting at word 0. The core is held in
// reset during the load and for REL_DLY cycles after the last write.
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int REL_DLY = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [ADDR_W:0] len,
    input  logic            abort,
    imem_loader_if.master   bus,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [1:0]      dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int              DLY_W = (REL_DLY > 1) ? $clog2(REL_DLY) : 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       shift_q, shift_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              we_q, we_d;

    // Next-state and next-output logic for the load sequence.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        dly_d      = dly_q;
        core_rst_d = core_rst_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((len != '0) && (len <= DEPTH)) begin
                        len_d      = len;
                        cnt_d      = '0;
                        idx_d      = '0;
                        core_rst_d = 1'b1;
                        state_d    = RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                // abort wins over a byte offered in the same cycle.
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (bus.byte_valid) begin
                    // Shift left so the first byte ends up in bits [31:24].
                    shift_d = {shift_q[23:0], bus.byte_data};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + (ADDR_W+1)'(1);
                    dly_d = '0;
                    if (cnt_d == len_q) begin
                        if (REL_DLY == 0) begin
                            core_rst_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (dly_q == DLY_W'(REL_DLY - 1)) begin
                    core_rst_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // The strobe is a flop so it cannot glitch when the state changes.
        we_d = (state_d == WRITE);
    end

    // State and output registers; reset holds the core and clears everything else.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            dly_q      <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            dly_q      <= dly_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            we_q       <= we_d;
        end
    end

    assign bus.byte_ready = (state_q == RECV);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = cnt_q[ADDR_W-1:0];
    assign bus.imem_wdata = shift_q;
    assign core_rst       = core_rst_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader. Stimulus pushes the expected memory writes into a
// queue. A negedge monitor pops the queue and compares on every imem_we.
module tb_imem_loader;
    localparam int AW = 2;
    localparam int RD = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   len = '0;
    logic          core_rst, busy, done, err;
    logic [1:0]    dbg_state;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW), .REL_DLY(RD)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .bus      (bus),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [AW+31:0] exp_q[$];
    int we_cyc[$];
    int cyc = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_we_cyc = -100;
    logic prev_core_rst = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: checks each write against the queue and checks release timing.
    always @(negedge CLK) begin
        logic [AW+31:0] e;
        cyc++;
        if (RST) begin
            if (bus.imem_we) begin
                we_cnt++;
                we_cyc.push_back(cyc);
                last_we_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", {bus.imem_addr, bus.imem_wdata}, e);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_core_rst", core_rst, 0);
                chk("pre_done_core_rst", prev_core_rst, 1);
                chk("release_delay", cyc - last_we_cyc, RD + 1);
            end
            if (err) err_cnt++;
            prev_core_rst = core_rst;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [AW:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        int n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        forever begin
            ok = bus.byte_ready;
            tick();
            if (ok) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL byte_timeout: byte %0h not accepted within 50 cycles", b);
                break;
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy) begin
            tick();
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL idle_timeout: busy still %0d after 200 cycles", busy);
                break;
            end
        end
        tick();
    endtask

    // ---------------- stimulus ----------------
    int exp_done = 0;
    int exp_err  = 0;
    int base;
    logic [7:0] bytes16 [16];

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        RST = 1'b0;
        repeat (3) tick();
        chk("rst_core_rst", core_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_byte_ready", bus.byte_ready, 0);
        chk("rst_imem_we", bus.imem_we, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        RST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_core_rst", core_rst, 1);
            chk("idle_busy", busy, 0);
            chk("idle_byte_ready", bus.byte_ready, 0);
            chk("idle_imem_we", bus.imem_we, 0);
        end

        // Two-word load with byte_valid held high.
        we_cyc.delete();
        exp_q.push_back({2'd0, 32'h20080005});
        exp_q.push_back({2'd1, 32'h0000000C});
        do_start(3'd2);
        chk("start_busy", busy, 1);
        chk("start_byte_ready", bus.byte_ready, 1);
        chk("start_core_rst", core_rst, 1);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
        wait_idle();
        exp_done++;
        chk("two_word_writes", we_cyc.size(), 2);
        if (we_cyc.size() == 2) chk("two_word_spacing", we_cyc[1] - we_cyc[0], 5);
        chk("two_word_done", done_cnt, exp_done);
        chk("two_word_released", core_rst, 0);

        // Single word with gaps in byte_valid.
        base = we_cnt;
        exp_q.push_back({2'd0, 32'hAABBCCDD});
        do_start(3'd1);
        chk("restart_core_rst", core_rst, 1);
        send_byte(8'hAA);
        tick(); tick();
        send_byte(8'hBB);
        send_byte(8'hCC);
        tick();
        send_byte(8'hDD);
        wait_idle();
        exp_done++;
        chk("gap_write_count", we_cnt - base, 1);
        chk("gap_done", done_cnt, exp_done);

        // Rejected starts and an ignored idle abort.
        base = we_cnt;
        do_start(3'd0);
        chk("bad0_err", err, 1);
        chk("bad0_state", dbg_state, 0);
        chk("bad0_busy", busy, 0);
        chk("bad0_core_rst", core_rst, 0);
        tick();
        do_start(3'd5);
        chk("bad5_err", err, 1);
        chk("bad5_state", dbg_state, 0);
        tick();
        exp_err += 2;
        chk("bad_err_count", err_cnt, exp_err);
        chk("bad_no_write", we_cnt - base, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_err", err, 0);
        chk("idle_abort_state", dbg_state, 0);

        // Abort coinciding with a valid byte after the 6th byte.
        base = we_cnt;
        exp_q.push_back({2'd0, 32'h11223344});
        do_start(3'd3);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h77;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.byte_valid = 1'b0;
        chk("abort_err", err, 1);
        chk("abort_core_rst", core_rst, 1);
        chk("abort_busy", busy, 0);
        repeat (3) tick();
        exp_err++;
        chk("abort_err_count", err_cnt, exp_err);
        chk("abort_write_count", we_cnt - base, 1);
        chk("abort_no_done", done_cnt, exp_done);
        exp_q.push_back({2'd0, 32'hA1B2C3D4});
        do_start(3'd1);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        wait_idle();
        exp_done++;
        chk("reload_done", done_cnt, exp_done);
        chk("reload_core_rst", core_rst, 0);

        // Full depth: 4 words for ADDR_W=2.
        base = we_cnt;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) bytes16[w*4+b] = 8'((w + 1) * 16 + b);
            exp_q.push_back({2'(w), bytes16[w*4], bytes16[w*4+1], bytes16[w*4+2], bytes16[w*4+3]});
        end
        do_start(3'd4);
        for (int i = 0; i < 16; i++) send_byte(bytes16[i]);
        wait_idle();
        repeat (3) tick();
        exp_done++;
        chk("full_write_count", we_cnt - base, 4);
        chk("full_done", done_cnt, exp_done);

        // Asynchronous reset in the middle of a load.
        do_start(3'd1);
        send_byte(8'hE1);
        send_byte(8'hE2);
        #3 RST = 1'b0;
        #1;
        chk("midrst_core_rst", core_rst, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_byte_ready", bus.byte_ready, 0);
        chk("midrst_imem_we", bus.imem_we, 0);
        chk("midrst_state", dbg_state, 0);
        tick();
        RST = 1'b1;
        tick();
        chk("after_rst_busy", busy, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
